dc_decouple_mc: RTL

- Multi-channel, parametrised DC-offset removal for the BPSK receive path. Sits between the matched-filter/ADC sample stream and the symbol timing/carrier loops.
- Each channel estimates its mean over a power-of-two window and tracks it with a shift-based PI loop. The tracked offset is subtracted from every sample with saturation.
- Adds bypass/P-only/PI modes, offset freeze, a lock indicator and an exact window average.

---
 rtl/dc_decouple_mc.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dc_decouple_mc.sv
// Multi-channel DC-offset removal. Each channel averages a 2^LOG_WINDOW
// sample window, tracks the average with a shift-based PI loop and
// subtracts the tracked offset from every sample with saturation.
module dc_decouple_mc #(
    parameter int SYMBOL_WIDTH = 16,
    parameter int SYMBOL_FRAC  = 14,
    parameter int CHANNELS     = 2,
    parameter int LOG_WINDOW   = 6,
    parameter int KP_SHIFT     = 2,
    parameter int KI_SHIFT     = 8,
    parameter int LOCK_THRESH  = 64,
    parameter int LOCK_COUNT   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [1:0]                       mode,
    input  logic                             freeze,
    input  logic                             in_valid,
    input  logic [CHANNELS*SYMBOL_WIDTH-1:0] in_data,
    output logic                             out_valid,
    output logic [CHANNELS*SYMBOL_WIDTH-1:0] out_data,
    output logic [CHANNELS*SYMBOL_WIDTH-1:0] offset_out,
    output logic                             locked
);
    localparam int SW  = SYMBOL_WIDTH;
    localparam int AW  = SW + LOG_WINDOW;   // window accumulator
    localparam int EW  = SW + 1;            // loop error
    localparam int IW  = SW + 4;            // integrator
    localparam int WW  = SW + 6;            // headroom for unsaturated sums
    localparam int LCW = $clog2(LOCK_COUNT + 1);

    localparam logic signed [WW-1:0] SW_MAX = {{(WW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [WW-1:0] SW_MIN = {{(WW-SW+1){1'b1}}, {(SW-1){1'b0}}};
    localparam logic signed [WW-1:0] IW_MAX = {{(WW-IW+1){1'b0}}, {(IW-1){1'b1}}};
    localparam logic signed [WW-1:0] IW_MIN = {{(WW-IW+1){1'b1}}, {(IW-1){1'b0}}};
    localparam logic signed [EW-1:0] THR_POS = EW'(LOCK_THRESH);
    localparam logic signed [EW-1:0] THR_NEG = -THR_POS;
    localparam logic [LOG_WINDOW-1:0] CNT_LAST  = '1;
    localparam logic [LCW-1:0]        LOCK_FULL = LCW'(LOCK_COUNT);

    // The fractional position only matters to the surrounding loops; guard
    // against configurations that make no sense for this block.
    if (SYMBOL_FRAC >= SYMBOL_WIDTH || LOG_WINDOW < 1) begin : g_param_check
        $error("dc_decouple_mc: SYMBOL_FRAC must be < SYMBOL_WIDTH and LOG_WINDOW >= 1");
    end

    typedef enum logic {ACCUM, UPDATE} state_t;

    state_t                  state_reg, state_next;
    logic [LOG_WINDOW-1:0]   cnt_reg;
    logic [LCW-1:0]          lock_cnt_reg, lock_cnt_next;
    logic                    locked_reg;
    logic                    out_valid_reg;
    logic [CHANNELS-1:0]     in_lock;
    logic                    accept, close, do_update, bypass_mode, p_mode;

    function automatic logic signed [SW-1:0] sat_sw(input logic signed [WW-1:0] v);
        if (v > SW_MAX)      return SW_MAX[SW-1:0];
        else if (v < SW_MIN) return SW_MIN[SW-1:0];
        else                 return v[SW-1:0];
    endfunction

    function automatic logic signed [IW-1:0] sat_iw(input logic signed [WW-1:0] v);
        if (v > IW_MAX)      return IW_MAX[IW-1:0];
        else if (v < IW_MIN) return IW_MIN[IW-1:0];
        else                 return v[IW-1:0];
    endfunction

    assign accept      = en & in_valid;
    assign close       = accept & (cnt_reg == CNT_LAST);
    assign do_update   = en & (state_reg == UPDATE);
    assign bypass_mode = (mode == 2'd0);
    assign p_mode      = (mode == 2'd1);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic signed [SW-1:0] in_ch, avg_reg, avg_next, offset_reg, out_reg;
        logic signed [AW-1:0] acc_reg, acc_sum;
        logic signed [IW-1:0] integ_reg, integ_next;
        logic signed [EW-1:0] err;
        logic signed [WW-1:0] off_w, p_term, i_term, sub_w;

        assign in_ch      = in_data[gi*SW +: SW];
        assign acc_sum    = acc_reg + AW'(in_ch);
        assign avg_next   = SW'(acc_sum >>> LOG_WINDOW);
        assign err        = EW'(avg_reg) - EW'(offset_reg);
        assign integ_next = sat_iw(WW'(integ_reg) + WW'(err));
        assign off_w      = WW'(offset_reg);
        assign p_term     = WW'(err) >>> KP_SHIFT;
        assign i_term     = WW'(integ_next) >>> KI_SHIFT;
        assign sub_w      = WW'(in_ch) - off_w;
        assign in_lock[gi] = (err <= THR_POS) && (err >= THR_NEG);

        // Output subtraction, window accumulation and loop-filter update.
        always_ff @(posedge clk) begin
            if (rst) begin
                acc_reg    <= '0;
                avg_reg    <= '0;
                offset_reg <= '0;
                integ_reg  <= '0;
                out_reg    <= '0;
            end else begin
                if (accept) begin
                    out_reg <= bypass_mode ? in_ch : sat_sw(sub_w);
                    acc_reg <= close ? '0 : acc_sum;
                    if (close) begin
                        avg_reg <= avg_next;
                    end
                end
                if (do_update && !freeze) begin
                    if (p_mode) begin
                        integ_reg  <= '0;
                        offset_reg <= sat_sw(off_w + p_term);
                    end else if (!bypass_mode) begin
                        integ_reg  <= integ_next;
                        offset_reg <= sat_sw(off_w + p_term + i_term);
                    end
                end
            end
        end

        assign out_data[gi*SW +: SW]   = out_reg;
        assign offset_out[gi*SW +: SW] = offset_reg;
    end

    // Window-close / update sequencing register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ACCUM;
        else     state_reg <= state_next;
    end

    // Next state: one UPDATE cycle after every closed window.
    always_comb begin
        state_next = state_reg;
        if (en) begin
            case (state_reg)
                ACCUM:   if (close) state_next = UPDATE;
                UPDATE:  state_next = ACCUM;
                default: state_next = ACCUM;
            endcase
        end
    end

    // Shared sample counter; wraps to zero on the window's last sample.
    always_ff @(posedge clk) begin
        if (rst)         cnt_reg <= '0;
        else if (accept) cnt_reg <= cnt_reg + LOG_WINDOW'(1);
    end

    assign lock_cnt_next = (&in_lock)
                         ? ((lock_cnt_reg == LOCK_FULL) ? lock_cnt_reg : lock_cnt_reg + LCW'(1))
                         : '0;

    // Count consecutive in-lock windows across all channels.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt_reg <= '0;
            locked_reg   <= 1'b0;
        end else if (do_update && !freeze) begin
            lock_cnt_reg <= lock_cnt_next;
            locked_reg   <= (lock_cnt_next == LOCK_FULL);
        end
    end

    // Output strobe follows accepted input by one cycle.
    always_ff @(posedge clk) begin
        if (rst) out_valid_reg <= 1'b0;
        else     out_valid_reg <= accept;
    end

    assign out_valid = out_valid_reg;
    assign locked    = locked_reg;
endmodule
